vga_timing_interface: RTL
=========================

Name: vga_timing_interface

Overview:
- Downstream display stage of the snake game on Basys 3. Generates 640x480@60 Hz VGA timing from the 100 MHz clock and issues the pixel address to the colour stage.
- Takes the registered 12-bit colour back from the colour stage and drives the VGA pins.
- Also produces the free-running frame counter used by the win-screen pattern.

Parameters:
- CLK_DIV, 4, CLK cycles per pixel (100 MHz / 4 = 25 MHz pixel rate)
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total 800
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); frame total 525

Ports:
- CLK  in  1  100 MHz Basys 3 clock, sole clock
- RESET  in  1  synchronous, active-high reset
- COLOUR_IN  in  12  colour from the colour stage, valid 1 CLK after ADDR changes
- ADDR  out  19  pixel address: [18:9] = X (0..639), [8:0] = Y (0..479)
- FRAME_COUNT  out  16  frames completed, wraps
- FRAME_TICK  out  1  one-CLK pulse when FRAME_COUNT increments
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_COLOUR  out  12  {R[3:0],G[3:0],B[3:0]} to DAC pins

Behaviour:
- Interface: one clock, CLK. RESET is synchronous and active-high.
- Reset values: all counters 0; ADDR 0; FRAME_COUNT 0; FRAME_TICK 0; VGA_HS 1; VGA_VS 1; VGA_COLOUR 0.
- Divider: 2-bit DivCnt counts 0..CLK_DIV-1. PIX_EN is high for the cycle in which DivCnt == CLK_DIV-1. The first PIX_EN after reset release is in the 4th cycle.
- Counters:
  - HCount (10b) and VCount (10b) advance only on PIX_EN.
  - HCount wraps 799 -> 0; on that wrap VCount increments.
  - VCount wraps 524 -> 0.
- Address stage (registered, updated on PIX_EN using the post-increment counts):
  - ADDR = {HCount, VCount[8:0]} when HCount < 640 and VCount < 480.
  - ADDR = 0 otherwise.
  - The colour stage registers its output, so COLOUR_IN for a given ADDR is stable from 1 CLK after the ADDR update until the next PIX_EN.
- Output stage (registered, updated on PIX_EN using the pre-increment counts, i.e. the pixel whose ADDR was issued one pixel period earlier):
  - VGA_HS = 0 iff 656 <= HCount <= 751.
  - VGA_VS = 0 iff 490 <= VCount <= 491.
  - VGA_COLOUR = COLOUR_IN if the pixel is visible, else 12'h000. Blanking always forces black, whatever COLOUR_IN is.
  - Total latency from counter/ADDR update to pin update: exactly 1 pixel period (4 CLK). Sync and colour stay mutually aligned.
- Frame counter:
  - On the PIX_EN where VCount goes 479 -> 480 (HCount wraps 799 -> 0), FRAME_COUNT increments by 1 and FRAME_TICK pulses high for that single CLK.
  - FRAME_COUNT wraps 16'hFFFF -> 0 with no saturation.
- Timing: frame period 800 x 525 x 4 = 1,680,000 CLK. HS low for 384 CLK per line. VS low for 2 lines = 6,400 CLK.
- Reset mid-frame: every register returns to its reset value on the next CLK edge. Timing restarts from (0,0) with no partial sync pulse; an HS/VS low in progress goes high immediately.
- RESET held high with PIX_EN conditions met: RESET has priority and nothing advances.
- All arithmetic is unsigned. Counter compares use full 10-bit width; VCount[9] is never placed on ADDR.

Test Plan:
- Reset then release -> all outputs at reset values while RESET=1. First ADDR change to {10'd1,9'd0} occurs at the 4th CLK after release. VGA_HS/VGA_VS stay 1 until HCount reaches 656.
- COLOUR_IN held at 12'hFFF for a full frame -> VGA_COLOUR = FFF only during the 640x480 visible window. It is 000 for the 160 blank pixels of every line and for lines 480..524. Count = 307,200 pixel periods of FFF per frame.
- Measure sync -> HS falling-edge spacing 3,200 CLK, HS low 384 CLK. VS falling-edge spacing 1,680,000 CLK, VS low 6,400 CLK. VS falls coincident with the HS timing grid (HCount 0 of line 490, delayed 1 pixel).
- Latency: bench models the colour stage as a 1-CLK register of f(ADDR) = ADDR[11:0] -> VGA_COLOUR at each pixel equals the low 12 bits of the ADDR issued exactly 4 CLK earlier.
- Frame counter: preload-free run of 3 frames -> FRAME_COUNT 0->1->2->3, one FRAME_TICK per frame at the VCount 479->480 edge. Force FRAME_COUNT = FFFF via a 65,535-frame accelerated run (V_VISIBLE=2, V_FP=V_SYNC=V_BP=1, H small) -> next tick wraps it to 0000.
- Mid-frame reset at HCount=700, VCount=490 (HS and VS both low) -> next CLK: VGA_HS=1, VGA_VS=1, VGA_COLOUR=0, ADDR=0, FRAME_COUNT=0. After release, timing resumes from (0,0) identically to power-on.

Source files
------------

// File: rtl/vga_timing_interface.sv
// ----------------------------------------------------------------------------
// vga_timing_interface
//
// Display back end of the snake game on Basys 3. A clock-enable divider
// produces the pixel rate from the 100 MHz board clock. Horizontal and
// vertical counters walk the full 800x525 raster. The pixel address is
// issued to the colour stage, and the registered colour that comes back is
// driven onto the VGA pins. A free-running frame counter is also kept for
// the win-screen pattern.
//
// Ports
//   CLK          in   1   100 MHz board clock (sole clock)
//   RESET        in   1   synchronous, active-high reset
//   COLOUR_IN    in  12   colour for the current ADDR, valid 1 CLK after ADDR
//   ADDR         out 19   {X[9:0], Y[8:0]} of the visible pixel, 0 in blanking
//   FRAME_COUNT  out 16   frames completed, wraps
//   FRAME_TICK   out  1   one-CLK pulse when FRAME_COUNT increments
//   VGA_HS       out  1   horizontal sync, active low
//   VGA_VS       out  1   vertical sync, active low
//   VGA_COLOUR   out 12   {R[3:0], G[3:0], B[3:0]} to the resistor DAC
// ----------------------------------------------------------------------------
module vga_timing_interface #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [11:0] COLOUR_IN,
    output logic [18:0] ADDR,
    output logic [15:0] FRAME_COUNT,
    output logic        FRAME_TICK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [11:0] VGA_COLOUR
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);

    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_count;
    logic [9:0]       r_v_count;
    logic [18:0]      r_addr;
    logic [15:0]      r_frame_count;
    logic             r_frame_tick;
    logic             r_hs;
    logic             r_vs;
    logic [11:0]      r_colour;

    // ------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------
    logic        w_pix_en;
    logic        w_h_wrap;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic        w_next_visible;
    logic [18:0] w_addr_next;
    logic        w_cur_visible;
    logic        w_hs_active;
    logic        w_vs_active;
    logic        w_frame_end;

    always_comb begin
        w_pix_en = (r_div_cnt == DIV_LAST);
        w_h_wrap = (r_h_count == H_LAST);

        w_h_next = w_h_wrap ? '0 : r_h_count + 10'd1;
        w_v_next = r_v_count;
        if (w_h_wrap) begin
            w_v_next = (r_v_count == V_LAST) ? '0 : r_v_count + 10'd1;
        end

        // The address leads the pins by one pixel: it is formed from the
        // post-increment counts so the colour stage has a full pixel period
        // to answer before the pins sample COLOUR_IN.
        w_next_visible = (w_h_next < H_VIS) && (w_v_next < V_VIS);
        w_addr_next    = w_next_visible ? {w_h_next, w_v_next[8:0]} : '0;

        // Pins use the pre-increment counts, i.e. the pixel whose address
        // went out one pixel earlier, keeping sync and colour aligned.
        w_cur_visible = (r_h_count < H_VIS) && (r_v_count < V_VIS);
        w_hs_active   = (r_h_count >= HS_FIRST) && (r_h_count <= HS_LAST);
        w_vs_active   = (r_v_count >= VS_FIRST) && (r_v_count <= VS_LAST);

        // Last pixel of the last visible line: the step out of it starts
        // vertical blanking and completes a frame.
        w_frame_end = w_h_wrap && (r_v_count == V_VIS_LAST);
    end

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div_cnt <= '0;
        end else if (w_pix_en) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Raster counters and address stage
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_addr    <= '0;
        end else if (w_pix_en) begin
            r_h_count <= w_h_next;
            r_v_count <= w_v_next;
            r_addr    <= w_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Pin stage
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_colour <= '0;
        end else if (w_pix_en) begin
            r_hs     <= ~w_hs_active;
            r_vs     <= ~w_vs_active;
            r_colour <= w_cur_visible ? COLOUR_IN : '0;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_frame_count <= '0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (w_pix_en && w_frame_end) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_frame_tick  <= 1'b1;
            end
        end
    end

    assign ADDR        = r_addr;
    assign FRAME_COUNT = r_frame_count;
    assign FRAME_TICK  = r_frame_tick;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_COLOUR  = r_colour;

endmodule
